// File: rtl/vdcm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : vdcm_pkg                                                      |
// | Brief   : Shared constants and types for the VDC-M substream read path  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
package vdcm_pkg;

   localparam int NSSM  = 4;
   localparam int DW    = 128;
   localparam int AW    = 12;
   localparam int DEPTH = 4050;

   typedef logic [1:0] ssm_id_t;

endpackage
`default_nettype wire

// File: rtl/vdcm_ssm_id_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : vdcm_ssm_id_queue                                             |
// | Brief   : 4-entry FIFO of substream ids, up to 4 pushes + 1 pop / cycle |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
module vdcm_ssm_id_queue
   import vdcm_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic [NSSM-1:0] push_mask,
   input  logic            pop,
   output logic [2:0]      count,
   output ssm_id_t         head
);

   ssm_id_t     r_mem [NSSM];
   logic [1:0]  r_rd_ptr;
   logic [1:0]  r_wr_ptr;
   logic [2:0]  r_count;
   logic [1:0]  w_slot [NSSM];
   logic [2:0]  w_npush;

   // Each set mask bit lands after all lower-indexed set bits.
   always_comb begin
      w_npush = '0;
      for (int i = 0; i < NSSM; i++) begin
         w_slot[i] = r_wr_ptr + w_npush[1:0];
         w_npush   = w_npush + {2'b00, push_mask[i]};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NSSM; i++) r_mem[i] <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         for (int i = 0; i < NSSM; i++) begin
            if (push_mask[i]) r_mem[w_slot[i]] <= ssm_id_t'(i);
         end
         r_wr_ptr <= r_wr_ptr + w_npush[1:0];
         if (pop) r_rd_ptr <= r_rd_ptr + 2'd1;
         r_count  <= r_count + w_npush - {2'b00, pop};
      end
   end

   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vdcm_ssm_rd_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : vdcm_ssm_rd_sched                                             |
// | Brief   : Demand-ordered bitstream RAM read scheduler for 4 substreams  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
module vdcm_ssm_rd_sched
   import vdcm_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,
   input  logic            start_dec,
   input  logic [AW-1:0]   base_addr,
   input  logic [NSSM-1:0] ssm_rd_req,
   output logic [NSSM-1:0] ssm_rd_busy,
   output logic [NSSM-1:0] ssm_rd_vld,
   output logic [DW-1:0]   ssm_rd_data,
   output logic            mem_rd_en,
   output logic [AW-1:0]   mem_rd_addr,
   input  logic [DW-1:0]   mem_rd_data,
   output logic [15:0]     words_rd,
   output logic            err_dup_req
);

   logic [NSSM-1:0] r_busy;
   logic [AW-1:0]   r_rd_addr;
   logic [15:0]     r_words;
   logic            r_err;
   logic            r_inflight;
   ssm_id_t         r_ret_id;
   logic [DW-1:0]   r_hold;

   logic [2:0]      w_count;
   ssm_id_t         w_head;
   logic            w_issue;
   logic [NSSM-1:0] w_acc;
   logic [NSSM-1:0] w_push;
   logic [NSSM-1:0] w_clr;

   assign w_issue = (w_count != 3'd0) && !start_dec;
   assign w_acc   = ssm_rd_req & ~r_busy;
   assign w_push  = start_dec ? '0 : w_acc;
   assign w_clr   = w_issue ? ({{(NSSM-1){1'b0}}, 1'b1} << w_head) : '0;

   vdcm_ssm_id_queue u_id_queue (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (start_dec),
      .push_mask (w_push),
      .pop       (w_issue),
      .count     (w_count),
      .head      (w_head)
   );

   // Busy drops at the issue edge so the return cycle can accept a new request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_busy     <= '0;
         r_rd_addr  <= '0;
         r_words    <= '0;
         r_err      <= 1'b0;
         r_inflight <= 1'b0;
         r_ret_id   <= '0;
      end else if (start_dec) begin
         r_busy     <= '0;
         r_rd_addr  <= base_addr;
         r_words    <= '0;
         r_err      <= 1'b0;
         r_inflight <= 1'b0;
      end else begin
         r_busy     <= (r_busy & ~w_clr) | w_acc;
         r_inflight <= w_issue;
         if (|(ssm_rd_req & r_busy)) r_err <= 1'b1;
         if (w_issue) begin
            r_ret_id  <= w_head;
            r_rd_addr <= (r_rd_addr == AW'(DEPTH - 1)) ? '0 : r_rd_addr + 1'b1;
            if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)           r_hold <= '0;
      else if (r_inflight) r_hold <= mem_rd_data;
   end

   assign ssm_rd_busy = r_busy;
   assign ssm_rd_vld  = r_inflight ? ({{(NSSM-1){1'b0}}, 1'b1} << r_ret_id) : '0;
   assign ssm_rd_data = r_inflight ? mem_rd_data : r_hold;
   assign mem_rd_en   = w_issue;
   assign mem_rd_addr = r_rd_addr;
   assign words_rd    = r_words;
   assign err_dup_req = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vdcm_ssm_rd_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : tb_vdcm_ssm_rd_sched                                          |
// | Brief   : Randomized bench for vdcm_ssm_rd_sched against a queue model  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
module tb_vdcm_ssm_rd_sched;

   logic         clk = 1'b0;
   logic         rstn;
   logic         start_dec;
   logic [11:0]  base_addr;
   logic [3:0]   ssm_rd_req;
   logic [3:0]   ssm_rd_busy;
   logic [3:0]   ssm_rd_vld;
   logic [127:0] ssm_rd_data;
   logic         mem_rd_en;
   logic [11:0]  mem_rd_addr;
   logic [127:0] mem_rd_data = '0;
   logic [15:0]  words_rd;
   logic         err_dup_req;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   int           q[$];
   logic [3:0]   m_busy = '0;
   int           m_addr = 0;
   int           m_words = 0;
   logic         m_err = 1'b0;
   logic         m_ret_v = 1'b0;
   int           m_ret_id = 0;
   int           m_ret_addr = 0;
   logic [127:0] m_hold = '0;

   always #5 clk = ~clk;

   vdcm_ssm_rd_sched dut (
      .clk         (clk),
      .rstn        (rstn),
      .start_dec   (start_dec),
      .base_addr   (base_addr),
      .ssm_rd_req  (ssm_rd_req),
      .ssm_rd_busy (ssm_rd_busy),
      .ssm_rd_vld  (ssm_rd_vld),
      .ssm_rd_data (ssm_rd_data),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .words_rd    (words_rd),
      .err_dup_req (err_dup_req)
   );

   function automatic logic [127:0] word_of(input int a);
      return {4{20'hC0DE0, a[11:0]}};
   endfunction

   // synchronous RAM: data valid the cycle after the strobe
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= word_of(int'(mem_rd_addr));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] req, input logic sd, input logic [11:0] base);
      logic [3:0]   ev;
      logic [3:0]   bold;
      logic         een;
      int           id;
      @(negedge clk);
      ssm_rd_req = req;
      start_dec  = sd;
      base_addr  = base;
      #3;
      een = !sd && (q.size() > 0);
      ev  = '0;
      if (m_ret_v) ev[m_ret_id] = 1'b1;
      chk("mem_rd_en", 128'(mem_rd_en), 128'(een));
      if (een) chk("mem_rd_addr", 128'(mem_rd_addr), 128'(m_addr));
      chk("ssm_rd_vld", 128'(ssm_rd_vld), 128'(ev));
      chk("ssm_rd_data", ssm_rd_data, m_ret_v ? word_of(m_ret_addr) : m_hold);
      chk("ssm_rd_busy", 128'(ssm_rd_busy), 128'(m_busy));
      chk("words_rd", 128'(words_rd), 128'(m_words));
      chk("err_dup_req", 128'(err_dup_req), 128'(m_err));
      if (m_ret_v) m_hold = word_of(m_ret_addr);
      if (sd) begin
         q.delete();
         m_busy  = '0;
         m_addr  = int'(base);
         m_words = 0;
         m_err   = 1'b0;
         m_ret_v = 1'b0;
      end else begin
         bold = m_busy;
         if (q.size() > 0) begin
            id          = q.pop_front();
            m_busy[id]  = 1'b0;
            m_ret_v     = 1'b1;
            m_ret_id    = id;
            m_ret_addr  = m_addr;
            m_addr      = (m_addr == 4049) ? 0 : m_addr + 1;
            if (m_words < 65535) m_words++;
         end else begin
            m_ret_v = 1'b0;
         end
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               if (bold[i]) m_err = 1'b1;
               else begin
                  m_busy[i] = 1'b1;
                  q.push_back(i);
               end
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 12'd0);
   endtask

   initial begin
      rstn       = 1'b0;
      start_dec  = 1'b0;
      base_addr  = '0;
      ssm_rd_req = '0;
      #12;
      chk("rst_busy", 128'(ssm_rd_busy), 128'(0));
      chk("rst_vld", 128'(ssm_rd_vld), 128'(0));
      chk("rst_data", ssm_rd_data, 128'(0));
      chk("rst_en", 128'(mem_rd_en), 128'(0));
      chk("rst_addr", 128'(mem_rd_addr), 128'(0));
      chk("rst_words", 128'(words_rd), 128'(0));
      chk("rst_err", 128'(err_dup_req), 128'(0));
      @(negedge clk);
      rstn = 1'b1;

      // single request
      step(4'b0000, 1'b1, 12'd0);
      step(4'b0001, 1'b0, 12'd0);
      idle(3);
      // all four at once
      step(4'b1111, 1'b0, 12'd0);
      idle(5);
      // interleaved
      step(4'b0110, 1'b0, 12'd0);
      step(4'b1001, 1'b0, 12'd0);
      idle(5);
      // wrap at the top of the buffer, re-requesting in each vld cycle
      step(4'b0000, 1'b1, 12'd4048);
      for (int k = 0; k < 4; k++) begin
         step(4'b0001, 1'b0, 12'd0);
         step(4'b0000, 1'b0, 12'd0);
      end
      idle(2);
      // duplicate request
      step(4'b0000, 1'b1, 12'd0);
      step(4'b0100, 1'b0, 12'd0);
      step(4'b0100, 1'b0, 12'd0);
      idle(4);
      // mid-operation restart
      step(4'b1111, 1'b0, 12'd0);
      step(4'b0000, 1'b0, 12'd0);
      step(4'b0000, 1'b1, 12'd100);
      idle(3);
      step(4'b0001, 1'b0, 12'd0);
      idle(3);

      // random traffic with occasional restarts, biased toward the wrap point
      for (int n = 0; n < 4000; n++) begin
         logic [3:0]  r;
         logic        s;
         logic [11:0] b;
         r = 4'($urandom) & 4'($urandom);
         s = ($urandom_range(0, 99) == 0);
         b = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(4044, 4049))
                                         : 12'($urandom_range(0, 4049));
         step(r, s, b);
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
